// File: rtl/dom_sqscmul_gf16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dom_sqscmul_gf16_pkg
// Brief   : Canright normal-basis GF(4)/GF(2^4) helpers and share-pair indexing
// Revision: 1.0
// ============================================================================
package dom_sqscmul_gf16_pkg;

    typedef logic [1:0] gf4_t;
    typedef logic [3:0] gf16_t;

    localparam int c_NIB = 4;

    function automatic gf4_t mul4(gf4_t x, gf4_t y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic gf4_t sq4(gf4_t x);
        return {x[0], x[1]};
    endfunction

    function automatic gf4_t sclN(gf4_t x);
        return {x[0], x[1] ^ x[0]};
    endfunction

    function automatic gf4_t sclN2(gf4_t x);
        return {x[1] ^ x[0], x[1]};
    endfunction

    function automatic gf16_t mul16(gf16_t x, gf16_t y);
        gf4_t e;
        e = sclN(mul4(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {mul4(x[3:2], y[3:2]) ^ e, mul4(x[1:0], y[1:0]) ^ e};
    endfunction

    function automatic gf16_t sqsc16(gf16_t x);
        return {sq4(x[3:2] ^ x[1:0]), sclN2(sq4(x[1:0]))};
    endfunction

    // Row-major index of the unordered pair {i,j} among n shares; symmetric in i,j.
    function automatic int pair_idx(int i, int j, int n);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * n - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dom_sqscmul_gf16_if.sv
`default_nettype none
// ============================================================================
// Module  : dom_sqscmul_gf16_if
// Brief   : Shared operand, randomness and result bus of the masked kernel
// Revision: 1.0
// ============================================================================
interface dom_sqscmul_gf16_if #(
    parameter int SHARES = 2
);
    logic [4*SHARES-1:0]            _XxDI;
    logic [4*SHARES-1:0]            _YxDI;
    logic [2*SHARES*(SHARES-1)-1:0] _ZxDI;
    logic [4*SHARES-1:0]            _QxDO;

    modport master (output _XxDI, output _YxDI, output _ZxDI, input  _QxDO);
    modport slave  (input  _XxDI, input  _YxDI, input  _ZxDI, output _QxDO);
endinterface
`default_nettype wire

// File: rtl/dom_sqscmul_gf16_mul_share.sv
`default_nettype none
// ============================================================================
// Module  : dom_gf16_mul_share
// Brief   : One cross-domain GF(2^4) product, remasked with Z and registered
// Revision: 1.0
// ============================================================================
module dom_gf16_mul_share
    import dom_sqscmul_gf16_pkg::*;
(
    input  wire logic  ClkxCI,
    input  wire logic  RstxRI,
    input  wire gf16_t x_i,
    input  wire gf16_t y_i,
    input  wire gf16_t z_i,
    output gf16_t      c_o
);
    gf16_t w_c_d;
    gf16_t r_c_q;

    // Randomness is folded in before the register so glitches never expose x_i*y_i.
    assign w_c_d = mul16(x_i, y_i) ^ z_i;

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_c_q <= '0;
        end else begin
            r_c_q <= w_c_d;
        end
    end

    assign c_o = r_c_q;
endmodule
`default_nettype wire

// File: rtl/dom_sqscmul_gf16.sv
`default_nettype none
// ============================================================================
// Module  : dom_sqscmul_gf16
// Brief   : DOM-masked Q = SqSc(X^Y) ^ X*Y over GF(2^4), one-cycle latency
// Revision: 1.0
// ============================================================================
module dom_sqscmul_gf16
    import dom_sqscmul_gf16_pkg::*;
#(
    parameter int SHARES    = 2,
    parameter bit PIPELINED = 1'b1
) (
    input  wire logic           ClkxCI,
    input  wire logic           RstxRI,
    dom_sqscmul_gf16_if.slave   bus
);
    gf16_t                  w_inner [SHARES];
    gf16_t                  w_cross [SHARES][SHARES];
    logic  [4*SHARES-1:0]   w_q_vec;

    genvar i, j;
    generate
        for (i = 0; i < SHARES; i++) begin : g_share
            gf16_t w_x;
            gf16_t w_y;
            gf16_t w_inner_d;

            assign w_x       = bus._XxDI[c_NIB*i +: c_NIB];
            assign w_y       = bus._YxDI[c_NIB*i +: c_NIB];
            assign w_inner_d = sqsc16(w_x ^ w_y) ^ mul16(w_x, w_y);

            if (PIPELINED) begin : g_pipe
                gf16_t r_inner_q;
                always_ff @(posedge ClkxCI) begin
                    if (RstxRI) begin
                        r_inner_q <= '0;
                    end else begin
                        r_inner_q <= w_inner_d;
                    end
                end
                assign w_inner[i] = r_inner_q;
            end else begin : g_comb
                assign w_inner[i] = w_inner_d;
            end

            for (j = 0; j < SHARES; j++) begin : g_cross
                if (j != i) begin : g_mul
                    localparam int c_K = pair_idx(i, j, SHARES);
                    dom_gf16_mul_share u_mul (
                        .ClkxCI (ClkxCI),
                        .RstxRI (RstxRI),
                        .x_i    (w_x),
                        .y_i    (bus._YxDI[c_NIB*j +: c_NIB]),
                        .z_i    (bus._ZxDI[c_NIB*c_K +: c_NIB]),
                        .c_o    (w_cross[i][j])
                    );
                end else begin : g_diag
                    assign w_cross[i][j] = '0;
                end
            end
        end
    endgenerate

    // Output compression only ever touches registered cross terms of one domain.
    always_comb begin
        w_q_vec = '0;
        for (int s = 0; s < SHARES; s++) begin
            gf16_t v_acc;
            v_acc = w_inner[s];
            for (int t = 0; t < SHARES; t++) begin
                v_acc = v_acc ^ w_cross[s][t];
            end
            w_q_vec[c_NIB*s +: c_NIB] = v_acc;
        end
    end

    assign bus._QxDO = w_q_vec;
endmodule
`default_nettype wire

// File: tb/tb_dom_sqscmul_gf16.sv
`default_nettype none
// ============================================================================
// Module  : tb_dom_sqscmul_gf16
// Brief   : Directed and exhaustive checks of the masked kernel, 2 and 3 shares
// Revision: 1.0
// ============================================================================
module tb_dom_sqscmul_gf16;

    logic ClkxCI;
    logic RstxRI;

    dom_sqscmul_gf16_if #(.SHARES(2)) if2 ();
    dom_sqscmul_gf16_if #(.SHARES(3)) if3 ();

    dom_sqscmul_gf16 #(.SHARES(2), .PIPELINED(1'b1)) u_dut2 (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .bus    (if2)
    );

    dom_sqscmul_gf16 #(.SHARES(3), .PIPELINED(1'b1)) u_dut3 (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .bus    (if3)
    );

    initial ClkxCI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    int n_cmp = 0;
    int n_bad = 0;

    // GF(4) normal-basis product table, index {a,b}; 3 is the multiplicative unit.
    localparam logic [1:0] GM4 [16] = '{2'd0, 2'd0, 2'd0, 2'd0,
                                        2'd0, 2'd2, 2'd3, 2'd1,
                                        2'd0, 2'd3, 2'd1, 2'd2,
                                        2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic [1:0] m4(logic [1:0] a, logic [1:0] b);
        return GM4[{a, b}];
    endfunction

    function automatic logic [3:0] golden(logic [3:0] x, logic [3:0] y);
        logic [3:0] s;
        logic [1:0] t;
        logic [1:0] sb;
        logic [1:0] mid;
        logic [1:0] e;
        logic [3:0] sqsc;
        logic [3:0] prod;
        s    = x ^ y;
        t    = s[3:2] ^ s[1:0];
        sb   = {s[0], s[1]};
        sqsc = {t[0], t[1], sb[1] ^ sb[0], sb[1]};
        mid  = m4(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
        e    = {mid[0], mid[1] ^ mid[0]};
        prod = {m4(x[3:2], y[3:2]) ^ e, m4(x[1:0], y[1:0]) ^ e};
        return sqsc ^ prod;
    endfunction

    function automatic logic [3:0] fold2(logic [7:0] q);
        return q[7:4] ^ q[3:0];
    endfunction

    function automatic logic [3:0] fold3(logic [11:0] q);
        return q[11:8] ^ q[7:4] ^ q[3:0];
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] m1;
        logic [3:0] m2;
        m1 = 4'($urandom);
        if2._XxDI = {x ^ m1, m1};
        m1 = 4'($urandom);
        if2._YxDI = {y ^ m1, m1};
        if2._ZxDI = 4'($urandom);
        m1 = 4'($urandom);
        m2 = 4'($urandom);
        if3._XxDI = {x ^ m1 ^ m2, m2, m1};
        m1 = 4'($urandom);
        m2 = 4'($urandom);
        if3._YxDI = {y ^ m1 ^ m2, m2, m1};
        if3._ZxDI = 12'($urandom);
    endtask

    task automatic chk_both(input string nm, input logic [3:0] exp);
        chk({nm, "_s2"}, 12'(fold2(if2._QxDO)), 12'(exp));
        chk({nm, "_s3"}, 12'(fold3(if3._QxDO)), 12'(exp));
    endtask

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
    } vec_t;

    vec_t vecs [6];

    logic [3:0]  px;
    logic [3:0]  py;
    logic [7:0]  q2a;
    logic [11:0] q3a;

    initial begin
        vecs[0] = '{x: 4'h0, y: 4'h0, q: 4'h0};
        vecs[1] = '{x: 4'h0, y: 4'h1, q: 4'hB};
        vecs[2] = '{x: 4'h1, y: 4'h0, q: 4'hB};
        vecs[3] = '{x: 4'h4, y: 4'h4, q: 4'hD};
        vecs[4] = '{x: 4'hF, y: 4'hF, q: 4'hF};
        vecs[5] = '{x: 4'h1, y: 4'h1, q: 4'h7};

        // Reset held with nonzero inputs: every share must read zero.
        RstxRI = 1'b1;
        drive(4'h9, 4'h6);
        @(posedge ClkxCI); #1;
        @(posedge ClkxCI); #1;
        chk("reset_q_s2", 12'(if2._QxDO), 12'h000);
        chk("reset_q_s3", if3._QxDO, 12'h000);

        // Directed table, back-to-back.
        RstxRI = 1'b0;
        for (int n = 0; n <= 6; n++) begin
            if (n > 0) begin
                @(posedge ClkxCI); #1;
                chk_both($sformatf("dir%0d", n - 1), vecs[n - 1].q);
            end
            if (n < 6) drive(vecs[n].x, vecs[n].y);
        end

        // Exhaustive, new operands every cycle; both (X,Y) orders are covered.
        for (int n = 0; n <= 256; n++) begin
            if (n > 0) begin
                @(posedge ClkxCI); #1;
                chk_both($sformatf("exh_%h_%h", px, py), golden(px, py));
            end
            if (n < 256) begin
                px = 4'(n >> 4);
                py = 4'(n);
                drive(px, py);
            end
        end

        // Same shares, different Z: unmasked result fixed, shares move by the Z sums.
        if2._XxDI = 8'h3A;
        if2._YxDI = 8'h96;
        if2._ZxDI = 4'h1;
        if3._XxDI = 12'h5A7;
        if3._YxDI = 12'hE21;
        if3._ZxDI = 12'h0F0;
        @(posedge ClkxCI); #1;
        q2a = if2._QxDO;
        q3a = if3._QxDO;
        chk("zind_a_s2", 12'(fold2(q2a)), 12'(golden(4'h9, 4'hF)));
        chk("zind_a_s3", 12'(fold3(q3a)), 12'(golden(4'h8, 4'hD)));
        if2._ZxDI = if2._ZxDI ^ 4'h6;
        if3._ZxDI = if3._ZxDI ^ 12'h5A3;
        @(posedge ClkxCI); #1;
        chk("zind_b_s2", 12'(fold2(if2._QxDO)), 12'(golden(4'h9, 4'hF)));
        chk("zind_b_s3", 12'(fold3(if3._QxDO)), 12'(golden(4'h8, 4'hD)));
        chk("zind_delta_s2", 12'(q2a ^ if2._QxDO), 12'h066);
        chk("zind_delta_s3", q3a ^ if3._QxDO, 12'hF69);

        // Reset mid-stream discards the in-flight result; output resumes one clock after release.
        drive(4'h7, 4'h9);
        RstxRI = 1'b1;
        @(posedge ClkxCI); #1;
        chk("midrst_q_s2", 12'(if2._QxDO), 12'h000);
        chk("midrst_q_s3", if3._QxDO, 12'h000);
        drive(4'hA, 4'h5);
        @(posedge ClkxCI); #1;
        chk("hold_rst_s2", 12'(if2._QxDO), 12'h000);
        chk("hold_rst_s3", if3._QxDO, 12'h000);
        RstxRI = 1'b0;
        drive(4'h3, 4'hC);
        @(posedge ClkxCI); #1;
        chk_both("post_rst", golden(4'h3, 4'hC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
